seg_seq_monitor: RTL

- Receive side of the counter-to-7-segment display path: samples an active-low 7-segment bus (same encoding the counter display drives), decodes it back to a 3-bit digit, and checks that digits advance 0..7 with wrap.
- Measures cycles between digit steps and checks them against the rate picked by V_SW[17:16].
- Sits beside the display counter as a self-check / on-board monitor; outputs go to LEDs or a second HEX.

---
 rtl/seg_seq_monitor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seg_seq_monitor.sv
// Receive-side monitor for a 7-segment counter display. It decodes the active-low segment bus back
// to a digit, checks that digits advance 0..7 with wrap, and measures the step period.
module seg_seq_monitor #(
   parameter int unsigned STABLE_CYC = 4,
   parameter int unsigned DIV0       = 25000000,
   parameter int unsigned DIV1       = 50000000,
   parameter int unsigned DIV2       = 100000000,
   parameter int unsigned DIV3       = 300000000,
   parameter int unsigned TOL        = 1024
) (
   input  logic        CLOCK_50,
   input  logic        V_SW0,
   input  logic [0:6]  seg_in,
   input  logic [1:0]  rate_sel,
   output logic [2:0]  digit_out,
   output logic        digit_valid,
   output logic        step_pulse,
   output logic        seq_err,
   output logic        bad_code,
   output logic [28:0] period_out,
   output logic        rate_ok
);

   localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC - 1);
   localparam logic [28:0] PerMax = '1;
   localparam logic [0:6] SegBlank = 7'b1111111;

   typedef enum logic [1:0] {StWait, StArm, StTrack} state_e;

   state_e          state_q, state_d;
   logic [0:6]      sync1_q, sync2_q, cand_q;
   logic [CntW-1:0] cnt_q;
   logic [28:0]     per_q, per_d;
   logic [2:0]      digit_q, digit_d;
   logic            valid_q, valid_d;
   logic            pulse_q, pulse_d;
   logic            seq_err_q, seq_err_d;
   logic            bad_q, bad_d;
   logic [28:0]     period_q, period_d;
   logic            rate_ok_q, rate_ok_d;

   logic       cand_legal, cand_blank;
   logic [2:0] cand_digit;
   logic       stable, accept, bad_hit;
   logic       is_inc, is_zero;
   logic [31:0] exp_per, per_ext, dev;
   logic       in_tol;

   always_comb begin
      cand_legal = 1'b1;
      cand_blank = 1'b0;
      cand_digit = 3'd0;
      case (cand_q)
         7'b0000001: cand_digit = 3'd0;
         7'b1001111: cand_digit = 3'd1;
         7'b0010010: cand_digit = 3'd2;
         7'b0000110: cand_digit = 3'd3;
         7'b1001100: cand_digit = 3'd4;
         7'b0100100: cand_digit = 3'd5;
         7'b0100000: cand_digit = 3'd6;
         7'b0001111: cand_digit = 3'd7;
         7'b1111111: begin
            cand_legal = 1'b0;
            cand_blank = 1'b1;
         end
         default: cand_legal = 1'b0;
      endcase
   end

   // A code counts as stable once the candidate has survived STABLE_CYC synced samples.
   assign stable  = (cnt_q >= CntMax) && (sync2_q == cand_q);
   assign accept  = stable && cand_legal && (!valid_q || (cand_digit != digit_q));
   assign bad_hit = stable && !cand_legal && !cand_blank;
   assign is_inc  = (cand_digit == 3'(digit_q + 3'd1));
   assign is_zero = (cand_digit == 3'd0);

   always_comb begin
      unique case (rate_sel)
         2'd0:    exp_per = 32'(DIV0 + 1);
         2'd1:    exp_per = 32'(DIV1 + 1);
         2'd2:    exp_per = 32'(DIV2 + 1);
         default: exp_per = 32'(DIV3 + 1);
      endcase
   end

   // Ordered subtraction keeps the deviation unsigned and overflow-free even at DIV3.
   assign per_ext = {3'b000, per_q};
   assign dev     = (per_ext >= exp_per) ? (per_ext - exp_per) : (exp_per - per_ext);
   assign in_tol  = (per_q != PerMax) && (dev <= TOL);

   always_ff @(posedge CLOCK_50 or posedge V_SW0) begin
      if (V_SW0) begin
         sync1_q <= SegBlank;
         sync2_q <= SegBlank;
         cand_q  <= SegBlank;
         cnt_q   <= '0;
      end else begin
         sync1_q <= seg_in;
         sync2_q <= sync1_q;
         if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= '0;
         end else if (cnt_q < CntMax) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge V_SW0) begin
      if (V_SW0) begin
         state_q <= StWait;
      end else begin
         state_q <= state_d;
      end
   end

   // A zero that is not a legal increment means the source counter was reset: re-arm.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         unique case (state_q)
            StWait:  state_d = StArm;
            default: state_d = (is_zero && !is_inc) ? StArm : StTrack;
         endcase
      end
   end

   always_comb begin
      digit_d   = digit_q;
      valid_d   = valid_q;
      pulse_d   = 1'b0;
      seq_err_d = seq_err_q;
      bad_d     = bad_q | bad_hit;
      period_d  = period_q;
      rate_ok_d = rate_ok_q;
      per_d     = (per_q == PerMax) ? per_q : per_q + 29'd1;
      if (accept) begin
         digit_d = cand_digit;
         valid_d = 1'b1;
         per_d   = 29'd1;
         if (state_q != StWait) begin
            pulse_d  = 1'b1;
            period_d = per_q;
            if (!is_inc && !is_zero) begin
               seq_err_d = 1'b1;
            end
            if ((state_q == StTrack) && (is_inc || !is_zero)) begin
               rate_ok_d = in_tol;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge V_SW0) begin
      if (V_SW0) begin
         digit_q   <= 3'd0;
         valid_q   <= 1'b0;
         pulse_q   <= 1'b0;
         seq_err_q <= 1'b0;
         bad_q     <= 1'b0;
         period_q  <= 29'd0;
         rate_ok_q <= 1'b0;
         per_q     <= 29'd0;
      end else begin
         digit_q   <= digit_d;
         valid_q   <= valid_d;
         pulse_q   <= pulse_d;
         seq_err_q <= seq_err_d;
         bad_q     <= bad_d;
         period_q  <= period_d;
         rate_ok_q <= rate_ok_d;
         per_q     <= per_d;
      end
   end

   assign digit_out   = digit_q;
   assign digit_valid = valid_q;
   assign step_pulse  = pulse_q;
   assign seq_err     = seq_err_q;
   assign bad_code    = bad_q;
   assign period_out  = period_q;
   assign rate_ok     = rate_ok_q;

endmodule
